// File: rtl/nsa_pkg.sv
// Shared types and helpers for the nibble-serial adder.
package nsa_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fa4.sv
// 4-bit ripple adder; the single arithmetic element reused for every nibble.
module fa4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] total;

  assign total = 5'(a) + 5'(b) + 5'(cin);
  assign sum   = total[3:0];
  assign cout  = total[4];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder computed one nibble per clock on a single fa4 with a registered carry.
// Define NSA_OVERFLOW_EN to add the registered signed-overflow output ovf.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NIBBLES*NIBBLE_W-1:0] a,
  input  logic [NIBBLES*NIBBLE_W-1:0] b,
  input  logic                        cin,
  output logic                        busy,
  output logic                        done,
  output logic [NIBBLES*NIBBLE_W-1:0] sum,
  output logic                        cout
`ifdef NSA_OVERFLOW_EN
  ,
  output logic                        ovf
`endif
);

  localparam int unsigned W     = NIBBLES * NIBBLE_W;
  localparam int unsigned IDX_W = (clog2(NIBBLES) > 0) ? clog2(NIBBLES) : 1;

  state_e state_q, state_d;
  logic   load, step, last;

  logic [W-1:0]     a_q, b_q, res_q, sum_q;
  logic             carry_q, cout_q, busy_q, done_q;
  logic [IDX_W-1:0] idx_q;

  logic [NIBBLE_W-1:0] fa_sum;
  logic                fa_cout;
  logic [W-1:0]        res_next;

  fa4 u_fa4 (
    .a    (a_q[NIBBLE_W-1:0]),
    .b    (b_q[NIBBLE_W-1:0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last = (idx_q == IDX_W'(NIBBLES - 1));

  // New nibble enters at the MSB end so the LSB nibble ends up at the bottom.
  assign res_next = (res_q >> NIBBLE_W) | (W'(fa_sum) << (W - NIBBLE_W));

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          load    = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        step = 1'b1;
        if (last) state_d = StDone;
      end
      StDone: begin
        if (start) begin
          load    = 1'b1;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == StRun);
      done_q  <= (state_d == StDone);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (load) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= cin;
      idx_q   <= '0;
    end else if (step) begin
      a_q     <= a_q >> NIBBLE_W;
      b_q     <= b_q >> NIBBLE_W;
      carry_q <= fa_cout;
      idx_q   <= idx_q + IDX_W'(1);
      res_q   <= res_next;
      if (last) begin
        sum_q  <= res_next;
        cout_q <= fa_cout;
      end
    end
  end

`ifdef NSA_OVERFLOW_EN
  logic ovf_q;

  // On the last nibble a_q/b_q hold the operand MSB nibble, so bit 3 is the sign.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (step && last) begin
      ovf_q <= (a_q[NIBBLE_W-1] == b_q[NIBBLE_W-1]) && (fa_sum[NIBBLE_W-1] != a_q[NIBBLE_W-1]);
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomised scoreboard bench for nibble_serial_adder against an arithmetic reference model.
module tb_nibble_serial_adder;

  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W       = NIBBLES * 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout;
  logic [W-1:0] sum;
`ifdef NSA_OVERFLOW_EN
  logic         ovf;
`endif

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;
  int   lat;
  int   d0;

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef NSA_OVERFLOW_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference: plain unsigned and signed integer arithmetic.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    exp_t   e;
    longint t, sg, lim;
    t   = longint'(x) + longint'(y) + longint'(ci);
    e.s = t[W-1:0];
    e.c = t[W];
    sg  = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
    lim = longint'(1) <<< (W - 1);
    e.o = (sg >= lim) || (sg < -lim);
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      check("busy_low_with_done", busy, 0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result at %0t", $time);
      end else begin
        me = q.pop_front();
        check("sum", sum, me.s);
        check("cout", cout, me.c);
`ifdef NSA_OVERFLOW_EN
        check("ovf", ovf, me.o);
`endif
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("busy_timeout", busy, 0);
    a     = x;
    b     = y;
    cin   = ci;
    start = 1'b1;
    q.push_back(model(x, y, ci));
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 100);
    if (!done) check("done_timeout", done, 1);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
`ifdef NSA_OVERFLOW_EN
    check("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Basic add and latency: done visible NIBBLES negedges after start_op returns.
    start_op(16'h0001, 16'h0001, 1'b0);
    wait_done(lat);
    check("latency", lat, NIBBLES);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("sum_held", sum, 16'h0002);

    start_op(16'hFFFF, 16'h0001, 1'b0);
    wait_done(lat);
    start_op(16'h0003, 16'h0005, 1'b1);
    wait_done(lat);
    start_op(16'h7FFF, 16'h0001, 1'b0);
    wait_done(lat);
    start_op(16'hFFFF, 16'hFFFF, 1'b1);
    wait_done(lat);
    @(negedge clk);

    // start held while busy with changing operands: only the first is used.
    d0    = done_cnt;
    a     = 16'h1111;
    b     = 16'h2222;
    cin   = 1'b0;
    start = 1'b1;
    q.push_back(model(16'h1111, 16'h2222, 1'b0));
    repeat (3) begin
      @(negedge clk);
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    repeat (4) @(negedge clk);
    check("single_done_when_held", done_cnt - d0, 1);

    // Reset in mid-operation aborts with no done.
    start_op(W'($urandom), W'($urandom), 1'b1);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    d0 = done_cnt;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_sum", sum, 0);
    check("abort_done", done, 0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    start_op(16'h0102, 16'h0304, 1'b0);
    wait_done(lat);
    check("latency_after_abort", lat, NIBBLES);

    // Back-to-back start in the DONE cycle.
    start_op(W'($urandom), W'($urandom), 1'b0);
    wait_done(lat);
    start_op(16'h1234, 16'h4321, 1'b0);
    check("done_falls_on_restart", done, 0);
    wait_done(lat);
    check("latency_back_to_back", lat, NIBBLES);

    // Random traffic with mixed gaps and back-to-back issue.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start_op(W'($urandom), W'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) wait_done(lat);
    end
    repeat (NIBBLES + 6) @(negedge clk);
    check("scoreboard_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
